// File: rtl/pnr_signal_conditioner_if.sv
// Bus bundle for the PNR signal conditioner.
// The master side drives samples and configuration; the slave side is the conditioner.
interface pnr_signal_conditioner_if #(
    parameter int WIDTH    = 14,
    parameter int CHANNELS = 2
);
    logic                         in_valid_i;
    logic [CHANNELS*WIDTH-1:0]    in_data_i;
    logic                         sync_i;
    logic                         cfg_load_i;
    logic [CHANNELS-1:0]          cfg_invert_i;
    logic [CHANNELS*WIDTH-1:0]    cfg_offset_i;
    logic                         sat_clr_i;
    logic                         out_valid_o;
    logic [CHANNELS*WIDTH-1:0]    out_data_o;
    logic [CHANNELS-1:0]          sat_flag_o;
    logic                         cfg_pending_o;

    modport master (
        output in_valid_i, in_data_i, sync_i, cfg_load_i, cfg_invert_i, cfg_offset_i, sat_clr_i,
        input  out_valid_o, out_data_o, sat_flag_o, cfg_pending_o
    );

    modport slave (
        input  in_valid_i, in_data_i, sync_i, cfg_load_i, cfg_invert_i, cfg_offset_i, sat_clr_i,
        output out_valid_o, out_data_o, sat_flag_o, cfg_pending_o
    );
endinterface

// File: rtl/pnr_signal_conditioner.sv
// Multi-channel polarity/baseline conditioner: optional inversion, offset
// subtraction and saturation, with frame-synchronous double-buffered config.
module pnr_signal_conditioner #(
    parameter int WIDTH    = 14,
    parameter int CHANNELS = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    pnr_signal_conditioner_if.slave   bus
);
    // Two guard bits: inversion of the most negative code and offset
    // subtraction can both exceed the sample range before clipping.
    localparam int EW = WIDTH + 2;
    localparam logic signed [EW-1:0]  SAT_MAX = {3'b000, {(WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0]  SAT_MIN = {3'b111, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]      MAX_W   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]      MIN_W   = {1'b1, {(WIDTH-1){1'b0}}};

    logic [CHANNELS-1:0]              r_act_inv, r_shd_inv;
    logic [CHANNELS-1:0][WIDTH-1:0]   r_act_off, r_shd_off;
    logic                             r_pending;

    logic [1:0]                       r_vld_pipe;
    logic [CHANNELS-1:0][EW-1:0]      r_s1_y;
    logic [CHANNELS-1:0][WIDTH-1:0]   r_s1_off;

    logic [CHANNELS-1:0][WIDTH-1:0]   r_out_data;
    logic [CHANNELS-1:0]              r_sat;

    logic                             w_apply;
    logic [CHANNELS-1:0]              w_eff_inv;
    logic [CHANNELS-1:0][WIDTH-1:0]   w_eff_off;
    logic [CHANNELS-1:0][EW-1:0]      w_y;
    logic [CHANNELS-1:0][WIDTH-1:0]   w_res;
    logic [CHANNELS-1:0]              w_clip;

    // A sync with pending config makes the sample presented with it use the new config.
    assign w_apply   = bus.sync_i & r_pending;
    assign w_eff_inv = w_apply ? r_shd_inv : r_act_inv;
    assign w_eff_off = w_apply ? r_shd_off : r_act_off;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        logic signed [EW-1:0] w_x, w_yl, w_offx, w_z;
        logic                 w_hi, w_lo;

        assign w_x    = EW'($signed(bus.in_data_i[c*WIDTH +: WIDTH]));
        assign w_yl   = w_eff_inv[c] ? -w_x : w_x;
        assign w_y[c] = w_yl;
        assign w_offx = EW'($signed(r_s1_off[c]));
        assign w_z    = $signed(r_s1_y[c]) - w_offx;
        assign w_hi   = (w_z > SAT_MAX);
        assign w_lo   = (w_z < SAT_MIN);
        assign w_clip[c] = w_hi | w_lo;
        assign w_res[c]  = w_hi ? MAX_W : (w_lo ? MIN_W : w_z[WIDTH-1:0]);
    end

    // Shadow capture on load, promotion to active on sync; a same-cycle load
    // keeps pending set because the sync consumed the older shadow.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_act_inv <= '0;
            r_act_off <= '0;
            r_shd_inv <= '0;
            r_shd_off <= '0;
            r_pending <= 1'b0;
        end else begin
            if (w_apply) begin
                r_act_inv <= r_shd_inv;
                r_act_off <= r_shd_off;
            end
            if (bus.cfg_load_i) begin
                r_shd_inv <= bus.cfg_invert_i;
                r_shd_off <= bus.cfg_offset_i;
                r_pending <= 1'b1;
            end else if (w_apply) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Stage 1: inverted sample plus the offset it must be paired with; valid shift register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_vld_pipe <= '0;
            r_s1_y     <= '0;
            r_s1_off   <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[0], bus.in_valid_i};
            if (bus.in_valid_i) begin
                r_s1_y   <= w_y;
                r_s1_off <= w_eff_off;
            end
        end
    end

    // Stage 2: clipped result held between valid samples; sticky flags where set beats clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_out_data <= '0;
            r_sat      <= '0;
        end else begin
            if (r_vld_pipe[0])
                r_out_data <= w_res;
            r_sat <= (r_sat & ~{CHANNELS{bus.sat_clr_i}}) | (w_clip & {CHANNELS{r_vld_pipe[0]}});
        end
    end

    assign bus.out_valid_o   = r_vld_pipe[1];
    assign bus.out_data_o    = r_out_data;
    assign bus.sat_flag_o    = r_sat;
    assign bus.cfg_pending_o = r_pending;

endmodule

// File: tb/tb_pnr_signal_conditioner.sv
// Directed bench for pnr_signal_conditioner: expected outputs are queued at
// issue time and popped by an independent monitor on the falling edge.
module tb_pnr_signal_conditioner;
    localparam int W = 14;
    localparam int C = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pnr_signal_conditioner_if #(.WIDTH(W), .CHANNELS(C)) bus_if ();

    pnr_signal_conditioner #(.WIDTH(W), .CHANNELS(C)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if)
    );

    logic [C*W-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    function automatic logic [C*W-1:0] pack(input int a, input int b);
        logic [W-1:0] la, lb;
        la = a[W-1:0];
        lb = b[W-1:0];
        return {lb, la};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: every presented output must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus_if.out_valid_o !== 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got ch0=%0d ch1=%0d expected no output",
                         $signed(bus_if.out_data_o[W-1:0]), $signed(bus_if.out_data_o[2*W-1:W]));
            end else begin
                logic [C*W-1:0] e;
                e = exp_q.pop_front();
                if (bus_if.out_data_o !== e)  begin
                    errors++;
                    $display("FAIL out_data: got ch0=%0d ch1=%0d expected ch0=%0d ch1=%0d",
                             $signed(bus_if.out_data_o[W-1:0]), $signed(bus_if.out_data_o[2*W-1:W]),
                             $signed(e[W-1:0]), $signed(e[2*W-1:W]));
                end
            end
        end
    end

    // One clock of stimulus; valid samples with push=1 queue their expected result.
    task automatic step(input logic v, input int d0, input int d1, input logic sy,
                        input logic ld, input logic [1:0] inv, input int o0, input int o1,
                        input logic clr, input logic push, input int e0, input int e1);
        bus_if.in_valid_i   = v;
        bus_if.in_data_i    = pack(d0, d1);
        bus_if.sync_i       = sy;
        bus_if.cfg_load_i   = ld;
        bus_if.cfg_invert_i = inv;
        bus_if.cfg_offset_i = pack(o0, o1);
        bus_if.sat_clr_i    = clr;
        if (v && push) exp_q.push_back(pack(e0, e1));
        @(posedge clk);
        #1;
        bus_if.in_valid_i   = 1'b0;
        bus_if.in_data_i    = '0;
        bus_if.sync_i       = 1'b0;
        bus_if.cfg_load_i   = 1'b0;
        bus_if.cfg_invert_i = '0;
        bus_if.cfg_offset_i = '0;
        bus_if.sat_clr_i    = 1'b0;
    endtask

    task automatic samp(input int d0, input int d1, input logic sy, input int e0, input int e1);
        step(1'b1, d0, d1, sy, 1'b0, 2'b00, 0, 0, 1'b0, 1'b1, e0, e1);
    endtask

    task automatic load(input logic [1:0] inv, input int o0, input int o1);
        step(1'b0, 0, 0, 1'b0, 1'b1, inv, o0, o1, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic clear_flags();
        step(1'b0, 0, 0, 1'b0, 1'b0, 2'b00, 0, 0, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 0, 0, 1'b0, 1'b0, 2'b00, 0, 0, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.in_valid_i   = 1'b0;
        bus_if.in_data_i    = '0;
        bus_if.sync_i       = 1'b0;
        bus_if.cfg_load_i   = 1'b0;
        bus_if.cfg_invert_i = '0;
        bus_if.cfg_offset_i = '0;
        bus_if.sat_clr_i    = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_out_valid", int'(bus_if.out_valid_o), 0);
        chk("rst_out_data",  int'(bus_if.out_data_o), 0);
        chk("rst_sat_flag",  int'(bus_if.sat_flag_o), 0);
        chk("rst_pending",   int'(bus_if.cfg_pending_o), 0);
        rst = 1'b0;
        idle(1);

        // Pass-through with default config, then hold when idle.
        samp(100, -200, 1'b0, 100, -200);
        samp(-1, 0, 1'b0, -1, 0);
        idle(3);
        chk("hold_out_data", int'(bus_if.out_data_o), int'(pack(-1, 0)));

        // Loaded config waits for sync; the sync sample already uses it.
        load(2'b01, 0, 0);
        chk("pending_after_load", int'(bus_if.cfg_pending_o), 1);
        samp(300, 7, 1'b0, 300, 7);
        chk("pending_no_sync", int'(bus_if.cfg_pending_o), 1);
        samp(500, 10, 1'b1, -500, 10);
        chk("pending_after_sync", int'(bus_if.cfg_pending_o), 0);
        idle(3);

        // Inverting the most negative code clips instead of wrapping.
        samp(-8192, 0, 1'b0, 8191, 0);
        samp(8191, 0, 1'b0, -8191, 0);
        idle(3);
        chk("sat_after_neg_full", int'(bus_if.sat_flag_o), 1);
        clear_flags();
        chk("sat_after_clr", int'(bus_if.sat_flag_o), 0);

        // Offset pushes past both rails; exact-rail results do not flag.
        load(2'b00, -100, 100);
        samp(8150, -8150, 1'b1, 8191, -8192);
        idle(3);
        chk("sat_both_rails", int'(bus_if.sat_flag_o), 3);
        clear_flags();
        chk("sat_clr_both", int'(bus_if.sat_flag_o), 0);
        samp(8091, -8092, 1'b0, 8191, -8192);
        idle(3);
        chk("sat_exact_rail", int'(bus_if.sat_flag_o), 0);

        // Same-cycle load and sync with nothing pending: old config stays, pending set.
        step(1'b1, 50, 50, 1'b1, 1'b1, 2'b01, 0, 0, 1'b0, 1'b1, 150, -50);
        chk("pending_load_sync", int'(bus_if.cfg_pending_o), 1);
        samp(50, 50, 1'b1, -50, 50);
        chk("pending_second_sync", int'(bus_if.cfg_pending_o), 0);
        // Clipped sample reaches stage 2 on the same edge as the clear: set wins.
        samp(-8192, 0, 1'b0, 8191, 0);
        clear_flags();
        chk("sat_set_beats_clr", int'(bus_if.sat_flag_o), 1);
        idle(2);
        clear_flags();
        chk("sat_clr_final", int'(bus_if.sat_flag_o), 0);

        // Reset with samples in flight and a pending config.
        load(2'b11, 5, 5);
        chk("pending_before_rst", int'(bus_if.cfg_pending_o), 1);
        step(1'b1, 1, 2, 1'b0, 1'b0, 2'b00, 0, 0, 1'b0, 1'b0, 0, 0);
        step(1'b1, 3, 4, 1'b0, 1'b0, 2'b00, 0, 0, 1'b0, 1'b0, 0, 0);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", int'(bus_if.out_valid_o), 0);
        chk("midrst_out_data",  int'(bus_if.out_data_o), 0);
        chk("midrst_pending",   int'(bus_if.cfg_pending_o), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idle(1);
            chk("no_stale_valid", int'(bus_if.out_valid_o), 0);
        end
        samp(100, -200, 1'b0, 100, -200);
        idle(3);

        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
